// File: rtl/uart_tx_periph.sv
// uart_tx_periph: memory-mapped 8N1 (LSB first) UART transmitter with a TX FIFO.
// Bus reads are registered; the serializer drains the FIFO while tx_en is set.
module uart_tx_periph #(
  parameter int unsigned FIFO_DEPTH = 8,
  parameter logic [15:0] DIV_RESET  = 16'd868
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        en_i,
  input  logic [3:0]  addr_i,
  input  logic [3:0]  we_i,
  input  logic [31:0] data_i,
  output logic [31:0] data_o,
  output logic        tx_o,
  output logic        irq_o
);

  // state | meaning
  // IDLE  | line high, waiting for tx_en and a queued byte
  // START | start bit (low) for DIVISOR cycles
  // DATA  | eight data bits, LSB first, DIVISOR cycles each
  // STOP  | stop bit (high); chains straight into START when more data is queued
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  localparam int unsigned PW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = PW + 1;

  localparam logic [1:0] SEL_TXDATA  = 2'd0;
  localparam logic [1:0] SEL_STATUS  = 2'd1;
  localparam logic [1:0] SEL_DIVISOR = 2'd2;
  localparam logic [1:0] SEL_CTRL    = 2'd3;

  state_t        state;
  logic [7:0]    fifo_mem [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic [7:0]    count_b;
  logic          full;
  logic          empty;
  logic          overflow;
  logic [15:0]   divisor;
  logic [15:0]   div_next;
  logic          tx_en;
  logic          irq_en;
  logic [15:0]   bit_cnt;
  logic          tc;
  logic [2:0]    bit_idx;
  logic [7:0]    shift;
  logic [1:0]    sel;
  logic          wr;
  logic          rd;
  logic          push;
  logic          push_ok;
  logic          pop;
  logic          busy;
  logic [31:0]   rdata;
  logic          unused_bits;

  assign sel     = addr_i[3:2];
  assign wr      = en_i & (we_i != 4'h0);
  assign rd      = en_i & (we_i == 4'h0);
  assign full    = (count == CW'(FIFO_DEPTH));
  assign empty   = (count == '0);
  assign count_b = 8'(count);
  assign busy    = (state != IDLE);
  assign tc      = (bit_cnt == 16'd0);

  // Fullness is the pre-edge value, so a same-cycle pop never rescues a push.
  assign push    = wr & (sel == SEL_TXDATA) & we_i[0];
  assign push_ok = push & ~full;
  assign pop     = tx_en & ~empty & ((state == IDLE) | ((state == STOP) & tc));

  assign unused_bits = ^{addr_i[1:0], data_i[31:16]};

  // ---------------------------------------------------------------- FIFO
  always_ff @(posedge clk) begin
    if (push_ok) begin
      fifo_mem[wr_ptr] <= data_i[7:0];
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) begin
        wr_ptr <= wr_ptr + PW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      case ({push_ok, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // ------------------------------------------------------- register file
  always_comb begin
    div_next = divisor;
    if (we_i[0]) begin
      div_next[7:0] = data_i[7:0];
    end
    if (we_i[1]) begin
      div_next[15:8] = data_i[15:8];
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      divisor  <= DIV_RESET;
      tx_en    <= 1'b1;
      irq_en   <= 1'b0;
      overflow <= 1'b0;
    end else begin
      if (wr && (sel == SEL_DIVISOR)) begin
        // a zero divisor would stall the bit timer, so it is stored as 1
        divisor <= (div_next == 16'd0) ? 16'd1 : div_next;
      end
      if (wr && (sel == SEL_CTRL) && we_i[0]) begin
        tx_en  <= data_i[0];
        irq_en <= data_i[1];
      end
      if (push && full) begin
        overflow <= 1'b1;
      end else if (wr && (sel == SEL_STATUS) && we_i[0] && data_i[3]) begin
        overflow <= 1'b0;
      end
    end
  end

  always_comb begin
    rdata = 32'h0;
    case (sel)
      SEL_TXDATA:  rdata = 32'h0;
      SEL_STATUS:  rdata = {16'h0, count_b, 4'h0, overflow, busy, empty, full};
      SEL_DIVISOR: rdata = {16'h0, divisor};
      SEL_CTRL:    rdata = {30'h0, irq_en, tx_en};
      default:     rdata = 32'h0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      data_o <= 32'h0;
    end else if (rd) begin
      data_o <= rdata;
    end
  end

  // ---------------------------------------------------------- serializer
  // bit_cnt is a down-counter reloaded from DIVISOR at every bit start, so a
  // DIVISOR write lands on the next bit boundary.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= IDLE;
      tx_o    <= 1'b1;
      bit_cnt <= 16'd0;
      bit_idx <= 3'd0;
      shift   <= 8'h0;
    end else begin
      case (state)
        IDLE: begin
          tx_o <= 1'b1;
          if (pop) begin
            shift   <= fifo_mem[rd_ptr];
            bit_cnt <= divisor - 16'd1;
            tx_o    <= 1'b0;
            state   <= START;
          end
        end
        START: begin
          if (tc) begin
            bit_cnt <= divisor - 16'd1;
            bit_idx <= 3'd0;
            tx_o    <= shift[0];
            state   <= DATA;
          end else begin
            bit_cnt <= bit_cnt - 16'd1;
          end
        end
        DATA: begin
          if (tc) begin
            bit_cnt <= divisor - 16'd1;
            if (bit_idx == 3'd7) begin
              tx_o  <= 1'b1;
              state <= STOP;
            end else begin
              bit_idx <= bit_idx + 3'd1;
              shift   <= {1'b0, shift[7:1]};
              tx_o    <= shift[1];
            end
          end else begin
            bit_cnt <= bit_cnt - 16'd1;
          end
        end
        STOP: begin
          if (tc) begin
            if (pop) begin
              shift   <= fifo_mem[rd_ptr];
              bit_cnt <= divisor - 16'd1;
              tx_o    <= 1'b0;
              state   <= START;
            end else begin
              tx_o  <= 1'b1;
              state <= IDLE;
            end
          end else begin
            bit_cnt <= bit_cnt - 16'd1;
          end
        end
        default: begin
          tx_o  <= 1'b1;
          state <= IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      irq_o <= 1'b0;
    end else begin
      irq_o <= irq_en & empty & ~busy;
    end
  end

endmodule
